pc_stack_unit: RTL
==================

PC_STACK_UNIT -- requirements
Module: pc_stack_unit

Interface
REQ-001 Parameter ADDR_W, default 16, program-counter and target width in bits (range 4..32).
REQ-002 Parameter STACK_DEPTH, default 4, number of return-address stack entries (range 1..16).
REQ-003 Parameter RESET_VEC, default 0, value loaded into pc on reset.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 en  input  1  advance strobe; the op is accepted on a rising edge with en=1.
REQ-007 op  input  3  000 SEQ, 001 JMP, 010 BRC, 011 CALL, 100 RET; codes 101-111 behave as SEQ.
REQ-008 target  input  ADDR_W  destination for JMP, BRC and CALL.
REQ-009 br_flag_sel  input  1  BRC flag select: 0 selects c_flag, 1 selects z_flag.
REQ-010 br_flag_val  input  1  BRC is taken when the selected flag equals this value.
REQ-011 c_flag, z_flag  input  1 each  ALU carry and zero flags, sampled at acceptance.
REQ-012 pc  output  ADDR_W  current instruction address, registered.
REQ-013 sp  output  $clog2(STACK_DEPTH+1)  occupied stack entries (0..STACK_DEPTH), registered.
REQ-014 stack_full, stack_empty  output  1 each  registered; full when sp=STACK_DEPTH, empty when sp=0.
REQ-015 taken  output  1  registered; 1 for the cycle after an accepted JMP, taken BRC, CALL or RET.
REQ-016 fault  output  1  registered, sticky stack-misuse indicator.

Function
REQ-017 States: RUN, FAULT; state changes only on a rising edge or on reset.
REQ-018 RUN, en=0: pc, sp and the stack hold, and taken=0 on the next edge.
REQ-019 RUN, en=1, SEQ, or BRC not taken: pc <= pc+1 modulo 2^ADDR_W, and taken <= 0.
REQ-020 RUN, en=1, JMP, or BRC taken: pc <= target, and taken <= 1.
REQ-021 RUN, en=1, CALL with sp<STACK_DEPTH: push (pc+1) mod 2^ADDR_W into entry sp, sp <= sp+1, pc <= target, and taken <= 1.
REQ-022 RUN, en=1, RET with sp>0: pc <= entry sp-1, sp <= sp-1, and taken <= 1.
REQ-023 Increment wraps: pc=2^ADDR_W-1 goes to 0 for SEQ, and a CALL issued there pushes 0.
REQ-024 Stack is LIFO, and push and pop never occur in the same cycle.
REQ-025 CALL when full, or RET when empty, is a misuse, handled per REQ-031/REQ-032.
REQ-026 FAULT state: pc, sp, the stack and taken=0 hold, en and op are ignored, and the state is left only by reset.
REQ-027 Flag inputs are used only when op=BRC and are otherwise don't-care.
REQ-028 Every op takes effect with one-cycle latency: outputs reflect the op accepted on the previous edge.

Reset
REQ-029 rst=0 asynchronously forces pc=RESET_VEC, sp=0, stack_empty=1, stack_full=0, taken=0, fault=0 and state RUN; stack contents become don't-care.
REQ-030 Reset asserted mid-sequence, including while in FAULT, aborts all state, and the first op after rst rises executes from RESET_VEC.

Configuration
REQ-031 With macro PCU_FAULT_EN defined, a misuse sets fault=1, moves the state to FAULT, and leaves pc and sp unchanged.
REQ-032 Without PCU_FAULT_EN, fault is tied to 0 and the FAULT state does not exist.
REQ-033 Without PCU_FAULT_EN, CALL when full drops the push, jumps pc to target with sp unchanged, and sets taken=1.
REQ-034 Without PCU_FAULT_EN, RET when empty sets pc to RESET_VEC with sp unchanged, and sets taken=1.

Verification (ADDR_W=16, STACK_DEPTH=4, RESET_VEC=0)
REQ-035 Reset then 3 SEQ ops -> pc=0x0003, sp=0, stack_empty=1, taken=0 throughout.
REQ-036 pc=0x0010, BRC target=0x0040, sel=1, val=1, z_flag=1 -> pc=0x0040, taken=1; repeat with z_flag=0 -> pc=0x0041, taken=0.
REQ-037 CALL 0x0100 from pc=0x0005, then CALL 0x0200, then RET, RET -> pc sequence 0x0100, 0x0200, 0x0101, 0x0006; sp sequence 1, 2, 1, 0.
REQ-038 Reset then JMP 0xFFFF, SEQ -> pc=0x0000; JMP 0xFFFF, then CALL 0x0020, then RET -> pc=0x0000.
REQ-039 PCU_FAULT_EN defined: 4 CALLs make stack_full=1; a 5th CALL gives fault=1 with pc and sp held; further ops change nothing; reset clears fault, and pc=0x0000.
REQ-040 PCU_FAULT_EN undefined: RET on an empty stack from pc=0x0033 -> pc=0x0000, sp=0, fault=0, taken=1.

Source files
------------

// File: rtl/pc_stack_unit.sv
// pc_stack_unit: program counter with a return-address stack.
// Handles sequential, jump, conditional branch, call and return operations.
// Optional feature macro: PCU_FAULT_EN. When it is defined, stack misuse
// (CALL when full, RET when empty) latches a sticky fault and freezes the unit.
// When it is undefined, a CALL when full still jumps but drops the push, and
// a RET when empty returns to RESET_VEC.
module pc_stack_unit #(
  parameter int ADDR_W      = 16,
  parameter int STACK_DEPTH = 4,
  parameter int RESET_VEC   = 0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             en,
  input  logic [2:0]                       op,
  input  logic [ADDR_W-1:0]                target,
  input  logic                             br_flag_sel,
  input  logic                             br_flag_val,
  input  logic                             c_flag,
  input  logic                             z_flag,
  output logic [ADDR_W-1:0]                pc,
  output logic [$clog2(STACK_DEPTH+1)-1:0] sp,
  output logic                             stack_full,
  output logic                             stack_empty,
  output logic                             taken,
  output logic                             fault
);

  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_VEC);
  localparam logic [SP_W-1:0]   SP_MAX   = SP_W'(STACK_DEPTH);

  // Opcodes 000 and 101-111 all fall through to the sequential case.
  localparam logic [2:0] OP_JMP  = 3'b001;
  localparam logic [2:0] OP_BRC  = 3'b010;
  localparam logic [2:0] OP_CALL = 3'b011;
  localparam logic [2:0] OP_RET  = 3'b100;

  logic [ADDR_W-1:0] r_pc;
  logic [SP_W-1:0]   r_sp;
  logic              r_full;
  logic              r_empty;
  logic              r_taken;
  logic [ADDR_W-1:0] r_stack [STACK_DEPTH];

  logic [ADDR_W-1:0] w_pc_inc;
  logic [ADDR_W-1:0] w_pc_next;
  logic [SP_W-1:0]   w_sp_next;
  logic              w_taken_next;
  logic              w_push;
  logic [IDX_W-1:0]  w_push_idx;
  logic [IDX_W-1:0]  w_pop_idx;
  logic              w_sel_flag;
  logic              w_run;
  logic              w_fault;

  assign w_pc_inc   = r_pc + ADDR_W'(1);
  assign w_push_idx = IDX_W'(r_sp);
  assign w_pop_idx  = IDX_W'(r_sp - SP_W'(1));
  assign w_sel_flag = br_flag_sel ? z_flag : c_flag;

`ifdef PCU_FAULT_EN
  typedef enum logic {ST_RUN, ST_FAULT} state_t;

  state_t r_state;
  state_t w_state_next;
  logic   w_misuse;

  // State register: the FAULT state is only left through reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_RUN;
    else      r_state <= w_state_next;
  end

  // Next-state logic: an accepted misuse while running freezes the unit.
  always_comb begin
    w_state_next = r_state;
    if (r_state == ST_RUN && w_misuse) w_state_next = ST_FAULT;
  end

  // State decode: the datapath only advances in RUN; fault mirrors FAULT.
  always_comb begin
    w_run   = (r_state == ST_RUN);
    w_fault = (r_state == ST_FAULT);
  end
`else
  assign w_run   = 1'b1;
  assign w_fault = 1'b0;
`endif

  // Datapath decode: next pc, stack pointer, push request and taken flag.
  always_comb begin
    w_pc_next    = r_pc;
    w_sp_next    = r_sp;
    w_taken_next = 1'b0;
    w_push       = 1'b0;
`ifdef PCU_FAULT_EN
    w_misuse     = 1'b0;
`endif
    if (w_run && en) begin
      case (op)
        OP_JMP: begin
          w_pc_next    = target;
          w_taken_next = 1'b1;
        end
        OP_BRC: begin
          if (w_sel_flag == br_flag_val) begin
            w_pc_next    = target;
            w_taken_next = 1'b1;
          end else begin
            w_pc_next = w_pc_inc;
          end
        end
        OP_CALL: begin
          if (!r_full) begin
            w_push       = 1'b1;
            w_sp_next    = r_sp + SP_W'(1);
            w_pc_next    = target;
            w_taken_next = 1'b1;
          end else begin
`ifdef PCU_FAULT_EN
            w_misuse = 1'b1;
`else
            w_pc_next    = target;
            w_taken_next = 1'b1;
`endif
          end
        end
        OP_RET: begin
          if (!r_empty) begin
            w_pc_next    = r_stack[w_pop_idx];
            w_sp_next    = r_sp - SP_W'(1);
            w_taken_next = 1'b1;
          end else begin
`ifdef PCU_FAULT_EN
            w_misuse = 1'b1;
`else
            w_pc_next    = RESET_PC;
            w_taken_next = 1'b1;
`endif
          end
        end
        default: w_pc_next = w_pc_inc;
      endcase
    end
  end

  // Architectural registers: pc, stack pointer, status flags and taken.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc    <= RESET_PC;
      r_sp    <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
      r_taken <= 1'b0;
    end else begin
      r_pc    <= w_pc_next;
      r_sp    <= w_sp_next;
      r_full  <= (w_sp_next == SP_MAX);
      r_empty <= (w_sp_next == '0);
      r_taken <= w_taken_next;
    end
  end

  // Stack storage: contents are don't-care after reset, so no reset here.
  always_ff @(posedge clk) begin
    if (w_push) r_stack[w_push_idx] <= w_pc_inc;
  end

  assign pc          = r_pc;
  assign sp          = r_sp;
  assign stack_full  = r_full;
  assign stack_empty = r_empty;
  assign taken       = r_taken;
  assign fault       = w_fault;

endmodule
